// File: rtl/fpu_issue_arbiter.sv
// Round-robin issue of NUM_REQ requesters onto one shared pipelined fpu.
// A tag pipe follows each op so its result returns to the requester that sent it.
module fpu_issue_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int FPU_LATENCY = 4,
  parameter int ID_W        = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [32*NUM_REQ-1:0] req_opa,
  input  logic [32*NUM_REQ-1:0] req_opb,
  input  logic [3*NUM_REQ-1:0] req_op,
  input  logic [2*NUM_REQ-1:0] req_rmode,
  output logic [31:0]          fpu_opa,
  output logic [31:0]          fpu_opb,
  output logic [2:0]           fpu_op,
  output logic [1:0]           fpu_rmode,
  input  logic [31:0]          fpu_out,
  input  logic [7:0]           fpu_flags,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [31:0]          rsp_data,
  output logic [7:0]           rsp_flags,
  output logic                 rsp_illegal,
  output logic                 busy
);

  localparam int          DEPTH      = FPU_LATENCY + 1;
  localparam logic [31:0] QNAN       = 32'h7FC00000;
  localparam logic [7:0]  QNAN_FLAGS = 8'h02;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
    logic            ill;
  } tag_t;

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             hit;
  logic [ID_W-1:0]  sel;
  logic [31:0]      sel_opa;
  logic [31:0]      sel_opb;
  logic [2:0]       sel_op;
  logic [1:0]       sel_rmode;
  logic             sel_ill;

  logic [31:0]      opa_q, opa_d;
  logic [31:0]      opb_q, opb_d;
  logic [2:0]       op_q, op_d;
  logic [1:0]       rmode_q, rmode_d;

  tag_t [DEPTH-1:0] tag_q, tag_d;
  tag_t             ret_q;

  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic [7:0]         rsp_flags_q, rsp_flags_d;
  logic               rsp_ill_q, rsp_ill_d;

  // First pass covers ptr..top, second pass wraps to the bottom.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hit && req_valid[i] && (ID_W'(i) >= ptr_q)) begin
        hit = 1'b1;
        sel = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hit && req_valid[i]) begin
        hit = 1'b1;
        sel = ID_W'(i);
      end
    end
  end

  always_comb begin
    sel_opa   = '0;
    sel_opb   = '0;
    sel_op    = '0;
    sel_rmode = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == ID_W'(i)) begin
        sel_opa   = req_opa[32*i +: 32];
        sel_opb   = req_opb[32*i +: 32];
        sel_op    = req_op[3*i +: 3];
        sel_rmode = req_rmode[2*i +: 2];
      end
    end
  end

  assign sel_ill = sel_op[2];

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = hit && !rst && (sel == ID_W'(i));
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    op_d    = op_q;
    rmode_d = rmode_q;
    tag_d   = {tag_q[DEPTH-2:0], tag_t'('0)};
    if (hit) begin
      ptr_d    = (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
      tag_d[0] = '{vld: 1'b1, id: sel, ill: sel_ill};
      if (!sel_ill) begin
        opa_d   = sel_opa;
        opb_d   = sel_opb;
        op_d    = sel_op;
        rmode_d = sel_rmode;
      end
    end
  end

  // ret_q holds the entry that just left the tag pipe; fpu_out is valid now.
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    rsp_ill_d   = rsp_ill_q;
    if (ret_q.vld) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        rsp_valid_d[i] = (ret_q.id == ID_W'(i));
      end
      rsp_data_d  = ret_q.ill ? QNAN : fpu_out;
      rsp_flags_d = ret_q.ill ? QNAN_FLAGS : fpu_flags;
      rsp_ill_d   = ret_q.ill;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      op_q        <= '0;
      rmode_q     <= '0;
      tag_q       <= '0;
      ret_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_ill_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      op_q        <= op_d;
      rmode_q     <= rmode_d;
      tag_q       <= tag_d;
      ret_q       <= tag_q[DEPTH-1];
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_ill_q   <= rsp_ill_d;
    end
  end

  always_comb begin
    busy = ret_q.vld | (|rsp_valid_q);
    for (int s = 0; s < DEPTH; s++) begin
      busy = busy | tag_q[s].vld;
    end
  end

  assign fpu_opa     = opa_q;
  assign fpu_opb     = opb_q;
  assign fpu_op      = op_q;
  assign fpu_rmode   = rmode_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_flags   = rsp_flags_q;
  assign rsp_illegal = rsp_ill_q;

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Directed bench for fpu_issue_arbiter with a transaction-level model of
// grants, issue registers and response steering, checked every cycle.
module tb_fpu_issue_arbiter;
  localparam int N = 2;
  localparam int L = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [32*N-1:0] req_opa;
  logic [32*N-1:0] req_opb;
  logic [3*N-1:0] req_op;
  logic [2*N-1:0] req_rmode;
  logic [31:0]    fpu_opa;
  logic [31:0]    fpu_opb;
  logic [2:0]     fpu_op;
  logic [1:0]     fpu_rmode;
  logic [31:0]    fpu_out;
  logic [7:0]     fpu_flags;
  logic [N-1:0]   rsp_valid;
  logic [31:0]    rsp_data;
  logic [7:0]     rsp_flags;
  logic           rsp_illegal;
  logic           busy;

  logic [31:0] a_opa [N];
  logic [31:0] a_opb [N];
  logic [2:0]  a_op  [N];
  logic [1:0]  a_rm  [N];

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign req_opa[32*i +: 32]  = a_opa[i];
    assign req_opb[32*i +: 32]  = a_opb[i];
    assign req_op[3*i +: 3]     = a_op[i];
    assign req_rmode[2*i +: 2]  = a_rm[i];
  end

  fpu_issue_arbiter #(
    .NUM_REQ(N),
    .FPU_LATENCY(L),
    .ID_W(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_opa(req_opa),
    .req_opb(req_opb),
    .req_op(req_op),
    .req_rmode(req_rmode),
    .fpu_opa(fpu_opa),
    .fpu_opb(fpu_opb),
    .fpu_op(fpu_op),
    .fpu_rmode(fpu_rmode),
    .fpu_out(fpu_out),
    .fpu_flags(fpu_flags),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_flags(rsp_flags),
    .rsp_illegal(rsp_illegal),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in fpu: known results for the directed operands, a scramble otherwise.
  function automatic logic [39:0] fpu_fn(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    if (op == 3'd0 && a == 32'h3F800000 && b == 32'h40000000) return {8'h00, 32'h40400000};
    if (op == 3'd2 && a == 32'h40000000 && b == 32'h40000000) return {8'h00, 32'h40800000};
    if (op == 3'd1 && a == 32'h40400000 && b == 32'h3F800000) return {8'h00, 32'h40000000};
    if (op == 3'd3 && a == 32'h3F800000 && b == 32'h00000000) return {8'h81, 32'h7F800000};
    return {8'h10, a ^ b ^ {29'd0, op}};
  endfunction

  logic [39:0] fp_pipe [L+1];
  always @(posedge clk) begin
    fp_pipe[0] <= fpu_fn(fpu_op, fpu_opa, fpu_opb);
    for (int k = 1; k <= L; k++) fp_pipe[k] <= fp_pipe[k-1];
  end
  assign fpu_out   = fp_pipe[L][31:0];
  assign fpu_flags = fp_pipe[L][39:32];

  typedef struct {
    int          due;
    int          id;
    bit          ill;
    logic [39:0] res;
  } ent_t;

  ent_t        pend[$];
  int          m_ptr;
  int          cyc;
  logic [31:0] m_fa, m_fb;
  logic [2:0]  m_fop;
  logic [1:0]  m_frm;
  logic [N-1:0] m_rv;
  logic [31:0] m_rd;
  logic [7:0]  m_rf;
  logic        m_ri;
  int          n_chk;
  int          n_fail;
  int          rsp0_cnt;

  function automatic int pick(int p, logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (((v >> i) & 1) != 0) return i;
    end
    return -1;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    pend.delete();
    m_fa  = '0;
    m_fb  = '0;
    m_fop = '0;
    m_frm = '0;
    m_rv  = '0;
    m_rd  = '0;
    m_rf  = '0;
    m_ri  = 1'b0;
  endtask

  task automatic model_edge();
    int   g;
    ent_t e;
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      g = pick(m_ptr, req_valid);
      if (g >= 0) begin
        e.due = cyc + L + 2;
        e.id  = g;
        e.ill = a_op[g][2];
        e.res = e.ill ? {8'h02, 32'h7FC00000} : fpu_fn(a_op[g], a_opa[g], a_opb[g]);
        if (!e.ill) begin
          m_fa  = a_opa[g];
          m_fb  = a_opb[g];
          m_fop = a_op[g];
          m_frm = a_rm[g];
        end
        pend.push_back(e);
        m_ptr = (g + 1) % N;
      end
      m_rv = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        m_rv = N'(1) << pend[0].id;
        m_rd = pend[0].res[31:0];
        m_rf = pend[0].res[39:32];
        m_ri = pend[0].ill;
        void'(pend.pop_front());
      end
    end
  endtask

  task automatic compare_all();
    int         g;
    logic [N-1:0] er;
    if (rst) model_reset();
    er = '0;
    g  = pick(m_ptr, req_valid);
    if (!rst && g >= 0) er = N'(1) << g;
    chk("req_ready", req_ready, er);
    chk("rsp_valid", rsp_valid, m_rv);
    chk("busy", busy, (pend.size() > 0 || m_rv != 0));
    chk("fpu_opa", fpu_opa, m_fa);
    chk("fpu_opb", fpu_opb, m_fb);
    chk("fpu_op", fpu_op, m_fop);
    chk("fpu_rmode", fpu_rmode, m_frm);
    chk("rsp_data", rsp_data, m_rd);
    chk("rsp_flags", rsp_flags, m_rf);
    chk("rsp_illegal", rsp_illegal, m_ri);
    if (rsp_valid[0]) rsp0_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_req(int i, logic [2:0] op, logic [31:0] a, logic [31:0] b, logic [1:0] rm);
    a_op[i]  = op;
    a_opa[i] = a;
    a_opb[i] = b;
    a_rm[i]  = rm;
  endtask

  logic [N-1:0] t2_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [31:0]  t2_dat [4] = '{32'h40800000, 32'h40000000, 32'h40800000, 32'h40000000};
  int c0;

  initial begin
    n_chk = 0;
    n_fail = 0;
    rsp0_cnt = 0;
    cyc = 0;
    model_reset();
    rst = 1'b1;
    req_valid = 2'b01;
    for (int i = 0; i < N; i++) set_req(i, 3'd0, 32'd0, 32'd0, 2'd0);

    tick();
    tick();
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_fpu_opa", fpu_opa, 32'h0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    req_valid = 2'b00;
    tick();

    // single add from requester 0
    set_req(0, 3'd0, 32'h3F800000, 32'h40000000, 2'd1);
    req_valid = 2'b01;
    #1 chk("t1_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    repeat (6) tick();
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_data", rsp_data, 32'h40400000);
    chk("t1_flags", rsp_flags, 8'h00);
    repeat (4) tick();

    // divide by zero from requester 1
    set_req(1, 3'd3, 32'h3F800000, 32'h00000000, 2'd2);
    req_valid = 2'b10;
    #1 chk("t3_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    repeat (6) tick();
    chk("t3_rsp_valid", rsp_valid, 2'b10);
    chk("t3_data", rsp_data, 32'h7F800000);
    chk("t3_flags", rsp_flags, 8'h81);
    repeat (4) tick();

    // both requesters contend for four cycles
    set_req(0, 3'd2, 32'h40000000, 32'h40000000, 2'd0);
    set_req(1, 3'd1, 32'h40400000, 32'h3F800000, 2'd3);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1 chk("t2_grant", req_ready, t2_gnt[k]);
      tick();
    end
    req_valid = 2'b00;
    repeat (2) tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t2_rsp_valid", rsp_valid, t2_gnt[k]);
      chk("t2_data", rsp_data, t2_dat[k]);
    end
    repeat (4) tick();

    // illegal op leaves the fpu registers alone
    chk("t4_fpu_op_before", fpu_op, 3'd1);
    set_req(0, 3'd5, 32'h12345678, 32'h9ABCDEF0, 2'd1);
    req_valid = 2'b01;
    #1 chk("t4_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("t4_fpu_op_after", fpu_op, 3'd1);
    chk("t4_fpu_opa_after", fpu_opa, 32'h40400000);
    repeat (6) tick();
    chk("t4_rsp_valid", rsp_valid, 2'b01);
    chk("t4_illegal", rsp_illegal, 1'b1);
    chk("t4_data", rsp_data, 32'h7FC00000);
    chk("t4_flags", rsp_flags, 8'h02);
    tick();
    chk("t4_pulse_end", rsp_valid, 2'b00);
    chk("t4_data_hold", rsp_data, 32'h7FC00000);
    repeat (4) tick();

    // reset with three ops in flight
    set_req(0, 3'd0, 32'h3F800000, 32'h40000000, 2'd2);
    req_valid = 2'b01;
    repeat (3) tick();
    req_valid = 2'b00;
    repeat (2) tick();
    chk("t5_busy_inflight", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_async_fpu_opa", fpu_opa, 32'h0);
    chk("t5_async_fpu_opb", fpu_opb, 32'h0);
    chk("t5_async_rmode", fpu_rmode, 2'd0);
    chk("t5_async_busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t5_no_rsp", rsp_valid, 2'b00);
    end
    req_valid = 2'b11;
    #1 chk("t5_ptr_zero", req_ready, 2'b01);
    set_req(1, 3'd2, 32'h40000000, 32'h40000000, 2'd1);
    req_valid = 2'b10;
    #1 chk("t5_req1_grant", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    repeat (8) tick();

    // single requester streaming for ten cycles
    c0 = rsp0_cnt;
    set_req(0, 3'd0, 32'h3F800000, 32'h40000000, 2'd3);
    req_valid = 2'b01;
    for (int k = 0; k < 10; k++) begin
      #1 chk("t6_grant", req_ready, 2'b01);
      tick();
    end
    req_valid = 2'b00;
    repeat (6) tick();
    chk("t6_last_rsp", rsp_valid, 2'b01);
    chk("t6_busy_last", busy, 1'b1);
    tick();
    chk("t6_busy_drop", busy, 1'b0);
    chk("t6_rsp_count", rsp0_cnt - c0, 10);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
